// File: rtl/add_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : add_bist_if
// Description : Operand/result bus between the BIST driver and the add unit.
//               master : drives data0/data1/op, receives result (add_bist)
//               slave  : receives data0/data1/op, drives result (add unit)
// Revision    : 1.0 - initial release
// ============================================================================
interface add_bist_if #(
    parameter int XLEN = 32
);
    logic [XLEN-1:0] data0;
    logic [XLEN-1:0] data1;
    logic            op;
    logic [XLEN-1:0] result;

    modport master (
        output data0,
        output data1,
        output op,
        input  result
    );

    modport slave (
        input  data0,
        input  data1,
        input  op,
        output result
    );
endinterface
`default_nettype wire

// File: rtl/add_bist.sv
`default_nettype none
// ============================================================================
// Module      : add_bist
// Description : Built-in self-test driver/checker for an add/subtract unit.
//               On start, replays a fixed xorshift vector sequence onto the
//               add unit, checks every result in the same cycle and reports
//               pass/fail, a saturating error count and the first failing
//               operand pair.
// Ports       : clock, reset    - clock, synchronous active-high reset
//               start           - run request (honoured in IDLE/DONE)
//               op_sel, count   - operation and vector count, latched at start
//               bus             - add unit operands/result (master side)
//               busy, done      - running / one-cycle completion pulse
//               pass, errors    - verdict and mismatch count
//               fail_valid, fail_data0, fail_data1 - first mismatch capture
// Revision    : 1.0 - initial release
// ============================================================================
module add_bist #(
    parameter int          XLEN = 32,
    parameter logic [63:0] SEED = 64'h0000_0000_0000_0001
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            op_sel,
    input  logic [31:0]     count,
    add_bist_if.master      bus,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [15:0]     errors,
    output logic            fail_valid,
    output logic [XLEN-1:0] fail_data0,
    output logic [XLEN-1:0] fail_data1
);

    localparam logic [63:0] c_SEED_B = SEED ^ 64'h9E37_79B9_7F4A_7C15;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    function automatic logic [63:0] f_xorshift(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    logic [1:0]      r_state;
    logic [63:0]     r_a;
    logic [63:0]     r_b;
    logic [31:0]     r_count;
    logic [31:0]     r_idx;
    logic            r_op_sel;
    logic [XLEN-1:0] r_data0;
    logic [XLEN-1:0] r_data1;
    logic            r_op;
    logic            r_done;
    logic            r_pass;
    logic [15:0]     r_errors;
    logic            r_fail_valid;
    logic [XLEN-1:0] r_fail_data0;
    logic [XLEN-1:0] r_fail_data1;

    logic [1:0]      w_state_next;
    logic            w_accept;
    logic            w_last;
    logic [63:0]     w_a_step;
    logic [63:0]     w_b_step;
    logic [XLEN-1:0] w_expected;
    logic            w_mismatch;
    logic [15:0]     w_errors_next;

    // Next-state and per-cycle check logic
    always_comb begin
        w_state_next  = r_state;
        w_accept      = 1'b0;
        w_last        = (r_idx == (r_count - 32'd1));
        w_a_step      = f_xorshift(r_a);
        w_b_step      = f_xorshift(r_b);
        w_expected    = r_op ? (r_data0 - r_data1) : (r_data0 + r_data1);
        w_mismatch    = (bus.result != w_expected);
        w_errors_next = r_errors;

        if ((r_state == c_RUN) && w_mismatch && (r_errors != 16'hFFFF)) begin
            w_errors_next = r_errors + 16'd1;
        end

        case (r_state)
            c_IDLE, c_DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = (count != 32'd0) ? c_RUN : c_DONE;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_state_next = c_DONE;
                end
            end
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_a          <= SEED;
            r_b          <= c_SEED_B;
            r_count      <= 32'd0;
            r_idx        <= 32'd0;
            r_op_sel     <= 1'b0;
            r_data0      <= '0;
            r_data1      <= '0;
            r_op         <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_errors     <= 16'd0;
            r_fail_valid <= 1'b0;
            r_fail_data0 <= '0;
            r_fail_data1 <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;

            if (w_accept) begin
                r_count      <= count;
                r_op_sel     <= op_sel;
                r_idx        <= 32'd0;
                r_a          <= SEED;
                r_b          <= c_SEED_B;
                r_errors     <= 16'd0;
                r_fail_valid <= 1'b0;
                r_fail_data0 <= '0;
                r_fail_data1 <= '0;
                // A zero-length run completes immediately with a clean verdict
                r_pass       <= (count == 32'd0);
                r_done       <= (count == 32'd0);
                // Vector 0 is the seed pair itself; operands stay 0 outside RUN
                r_data0      <= (count != 32'd0) ? SEED[XLEN-1:0] : '0;
                r_data1      <= (count != 32'd0) ? c_SEED_B[XLEN-1:0] : '0;
                r_op         <= (count != 32'd0) ? op_sel : 1'b0;
            end else if (r_state == c_RUN) begin
                r_a      <= w_a_step;
                r_b      <= w_b_step;
                r_idx    <= r_idx + 32'd1;
                r_errors <= w_errors_next;

                if (w_mismatch && !r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_data0 <= r_data0;
                    r_fail_data1 <= r_data1;
                end

                if (w_last) begin
                    r_data0 <= '0;
                    r_data1 <= '0;
                    r_op    <= 1'b0;
                    r_done  <= 1'b1;
                    r_pass  <= (w_errors_next == 16'd0);
                end else begin
                    r_data0 <= w_a_step[XLEN-1:0];
                    r_data1 <= w_b_step[XLEN-1:0];
                    r_op    <= r_op_sel;
                end
            end
        end
    end

    assign bus.data0  = r_data0;
    assign bus.data1  = r_data1;
    assign bus.op     = r_op;
    assign busy       = (r_state == c_RUN);
    assign done       = r_done;
    assign pass       = r_pass;
    assign errors     = r_errors;
    assign fail_valid = r_fail_valid;
    assign fail_data0 = r_fail_data0;
    assign fail_data1 = r_fail_data1;

endmodule
`default_nettype wire

// File: tb/tb_add_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_bist
// Description : Self-checking bench for add_bist. Models the add unit (with a
//               stuck-at-zero result fault option), predicts the vector
//               sequence and final status, and compares on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_bist;

    localparam int          XLEN = 32;
    localparam logic [63:0] SEED = 64'h0000_0000_0000_0001;
    localparam logic [63:0] c_GOLD = 64'h9E37_79B9_7F4A_7C15;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            op_sel = 1'b0;
    logic [31:0]     count = 32'd0;
    logic            busy;
    logic            done;
    logic            pass;
    logic [15:0]     errors;
    logic            fail_valid;
    logic [XLEN-1:0] fail_data0;
    logic [XLEN-1:0] fail_data1;
    logic            fault = 1'b0;

    add_bist_if #(.XLEN(XLEN)) bus ();

    // Behavioural add unit, optionally stuck at zero
    assign bus.result = fault ? '0 :
                        (bus.op ? (bus.data0 - bus.data1) : (bus.data0 + bus.data1));

    add_bist #(.XLEN(XLEN), .SEED(SEED)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op_sel     (op_sel),
        .count      (count),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .errors     (errors),
        .fail_valid (fail_valid),
        .fail_data0 (fail_data0),
        .fail_data1 (fail_data1)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [XLEN-1:0] d0;
        logic [XLEN-1:0] d1;
        logic            op;
    } vec_t;

    vec_t            sb[$];
    int              total = 0;
    int              bad = 0;
    int              exp_err;
    logic            exp_fv;
    logic [XLEN-1:0] exp_fd0;
    logic [XLEN-1:0] exp_fd1;
    logic [XLEN-1:0] first_d0;
    logic [XLEN-1:0] first_d1;
    logic [XLEN-1:0] first_res;

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 7);
        y = y ^ (y << 17);
        return y;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fill the scoreboard with the vectors of an n-vector run and predict status
    task automatic build(input int n, input logic opv, input logic flt);
        logic [63:0]     a;
        logic [63:0]     b;
        vec_t            v;
        logic [XLEN-1:0] e;
        logic [XLEN-1:0] r;
        sb.delete();
        a = SEED;
        b = SEED ^ c_GOLD;
        exp_err = 0;
        exp_fv  = 1'b0;
        exp_fd0 = '0;
        exp_fd1 = '0;
        for (int i = 0; i < n; i++) begin
            v.d0 = a[XLEN-1:0];
            v.d1 = b[XLEN-1:0];
            v.op = opv;
            sb.push_back(v);
            e = opv ? (v.d0 - v.d1) : (v.d0 + v.d1);
            r = flt ? '0 : e;
            if (r != e) begin
                if (exp_err < 65535) exp_err++;
                if (!exp_fv) begin
                    exp_fv  = 1'b1;
                    exp_fd0 = v.d0;
                    exp_fd1 = v.d1;
                end
            end
            a = xs(a);
            b = xs(b);
        end
    endtask

    // Launch a run, pop/compare vectors while busy, then check final status.
    // A stray start with different count/op_sel is injected mid-run.
    task automatic run(input int n, input logic opv, input logic flt,
                       input bit chk_vec, output logic [31:0] sig);
        int   cycles;
        vec_t v;
        build(n, opv, flt);
        fault  = flt;
        count  = n;
        op_sel = opv;
        start  = 1'b1;
        @(negedge clock);
        start  = 1'b0;
        check("busy_first", busy, (n != 0));
        check("done_first", done, (n == 0));
        cycles = 0;
        sig    = 32'd0;
        while (busy === 1'b1 && cycles < n + 5) begin
            if (cycles == 0) begin
                first_d0  = bus.data0;
                first_d1  = bus.data1;
                first_res = bus.result;
            end
            if (sb.size() > 0) begin
                v = sb.pop_front();
                if (chk_vec) begin
                    check("vec_data0", bus.data0, v.d0);
                    check("vec_data1", bus.data1, v.d1);
                    check("vec_op", bus.op, v.op);
                end
            end
            sig = {sig[30:0], sig[31]} ^ bus.data0 ^ bus.data1;
            if (n >= 3 && cycles == 1) begin
                start  = 1'b1;
                count  = 32'd7;
                op_sel = ~opv;
            end else begin
                start  = 1'b0;
            end
            cycles++;
            @(negedge clock);
        end
        start = 1'b0;
        check("busy_cycles", cycles, n);
        check("done_pulse", done, 1'b1);
        check("pass", pass, (exp_err == 0));
        check("errors", errors, exp_err);
        check("fail_valid", fail_valid, exp_fv);
        check("fail_data0", fail_data0, exp_fd0);
        check("fail_data1", fail_data1, exp_fd1);
        @(negedge clock);
        check("done_width", done, 1'b0);
        check("pass_hold", pass, (exp_err == 0));
        check("errors_hold", errors, exp_err);
        fault = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_pass"}, pass, 1'b0);
        check({tag, "_errors"}, errors, 16'd0);
        check({tag, "_fail_valid"}, fail_valid, 1'b0);
        check({tag, "_fail_data0"}, fail_data0, '0);
        check({tag, "_fail_data1"}, fail_data1, '0);
        check({tag, "_data0"}, bus.data0, '0);
        check({tag, "_data1"}, bus.data1, '0);
        check({tag, "_op"}, bus.op, 1'b0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sig_a;
        logic [31:0] sig_b;
        logic [31:0] sig_c;

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_reset_outputs("reset");

        // Reset and start together: reset wins
        start = 1'b1;
        count = 32'd5;
        @(negedge clock);
        check("rst_start_busy", busy, 1'b0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clock);
        check("rst_start_idle", busy, 1'b0);

        // Short add run with known first vector
        run(4, 1'b0, 1'b0, 1'b1, sig_a);
        check("first_data0", first_d0, 32'h0000_0001);
        check("first_data1", first_d1, 32'h7F4A_7C14);
        check("first_result", first_res, 32'h7F4A_7C15);

        // Subtract runs; second must replay the first
        run(1000, 1'b1, 1'b0, 1'b1, sig_a);
        run(1000, 1'b1, 1'b0, 1'b1, sig_b);
        check("replay_sig", sig_b, sig_a);

        // Stuck-at-zero result
        run(100, 1'b0, 1'b1, 1'b1, sig_c);
        check("fault_errors", errors, 16'd100);
        check("fault_fd0", fail_data0, 32'h0000_0001);
        check("fault_fd1", fail_data1, 32'h7F4A_7C14);

        // Zero-length run
        run(0, 1'b0, 1'b0, 1'b1, sig_c);

        // Error counter saturation
        run(70000, 1'b0, 1'b1, 1'b0, sig_c);
        check("sat_errors", errors, 16'hFFFF);
        check("sat_pass", pass, 1'b0);

        // Reference uninterrupted 10-vector run
        run(10, 1'b0, 1'b0, 1'b1, sig_a);

        // Reset during a 10-vector run at cycle t+3
        count  = 32'd10;
        op_sel = 1'b0;
        start  = 1'b1;
        @(negedge clock);   // cycle t+1
        start  = 1'b0;
        @(negedge clock);   // cycle t+2
        @(negedge clock);   // cycle t+3
        reset  = 1'b1;
        @(negedge clock);
        reset  = 1'b0;
        check_reset_outputs("midrun_reset");
        @(negedge clock);
        check("midrun_idle", busy, 1'b0);

        // Restart reproduces the uninterrupted run
        run(10, 1'b0, 1'b0, 1'b1, sig_b);
        check("restart_sig", sig_b, sig_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/add_bist.md
# add_bist

Synthesizable built-in self-test driver and checker for the `add` unit, which computes `data0 + data1` or `data0 - data1` selected by `op`. It sits on the opposite side of the `add` interface: it drives `data0`/`data1`/`op` and receives `result`. A `start` request triggers a run of N pseudo-random vectors. Each vector is checked in the same cycle against an internal reference. The block then reports pass/fail, a saturating error count and the operands of the first failing vector.

## Interface
- `XLEN`, 32: operand/result width, 1..64.
- `SEED`, 64'h0000_0000_0000_0001: nonzero seed of generator A. Generator B seed is `SEED ^ 64'h9E37_79B9_7F4A_7C15`, which must also be nonzero.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run request; sampled in IDLE and DONE only.
- `op_sel` in 1: 0 = add, 1 = subtract; latched at start.
- `count` in 32: vectors per run; latched at start.
- `data0` out XLEN: operand to `add.data0`, registered.
- `data1` out XLEN: operand to `add.data1`, registered.
- `op` out 1: to `add.op`, registered.
- `result` in XLEN: from `add.result`; combinational path from `data0`/`data1`/`op`.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on entry to DONE.
- `pass` out 1: valid in DONE; 1 iff `errors == 0`.
- `errors` out 16: mismatch count, saturates at 16'hFFFF.
- `fail_valid` out 1: a mismatch has been captured this run.
- `fail_data0` out XLEN: `data0` of the first mismatch.
- `fail_data1` out XLEN: `data1` of the first mismatch.

## Operation
- Generators A and B: each is a 64-bit xorshift state. The step function is `x ^= x<<13; x ^= x>>7; x ^= x<<17`, computed 64-bit and truncated.
- Operands: `data0 = A[XLEN-1:0]`, `data1 = B[XLEN-1:0]`.
- Reference result:
  - `op == 0`: `expected = (data0 + data1) mod 2^XLEN`.
  - `op == 1`: `expected = (data0 - data1) mod 2^XLEN`, two's complement.
  - Carry and borrow are discarded.
- Mismatch: `result != expected` while in RUN.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On `start`: latch `count` and `op_sel`; load A and B with their seeds; clear `errors`, `fail_*` and `pass`.
  - Next state is RUN if `count != 0`, otherwise DONE.
  - Every run replays the identical vector sequence.
- RUN, each cycle:
  - Compare the current vector and update `errors` (saturating) and the first-fail capture.
  - Advance A and B; increment the vector counter.
  - After `count` checked vectors, go to DONE.
- DONE:
  - Assert `done` for 1 cycle; `pass`, `errors` and `fail_*` hold stable.
  - On `start`: behave exactly as IDLE on `start` (re-run).
  - Otherwise stay in DONE.
- `start` during RUN: ignored.
- `count` and `op_sel` changes during RUN: no effect until the next accepted start.
- First-fail capture: only the first mismatch of a run is captured; later mismatches only increment `errors`.
- Reset values:
  - State IDLE; all outputs 0.
  - Operands and `op` output 0.
  - Generator state registers hold the seeds; they are reloaded on every accepted start.

## Timing
- `start` accepted at edge t with `count = N ≥ 1`:
  - `busy = 1` and vector k (k = 0..N-1) is presented during cycle t+1+k.
  - It is checked at edge t+2+k.
  - State is DONE with `done = 1` in cycle t+N+1; `busy = 0` from that cycle.
- `count = 0`: DONE with `done = 1` in cycle t+1, `pass = 1`, `errors = 0`, no vectors driven.
- Vector 0 equals the seeds: `data0 = SEED[XLEN-1:0]`, `data1 = (SEED ^ 64'h9E37…7C15)[XLEN-1:0]`.
- The `add` unit must settle within one clock period; no pipeline stages are inside the `result` path.
- `reset` asserted in any state, including mid-RUN: all outputs hold reset values in the following cycle; no partial result is reported.
- Simultaneous `reset` and `start`: reset wins.
- Error saturation: when `errors == 16'hFFFF`, further mismatches leave `errors` unchanged; `pass` stays 0.

## Test plan
- Correct `add`, XLEN=32, SEED=1, op_sel=0, count=4:
  - Cycle t+1: `data0 = 32'h00000001`, `data1 = 32'h7F4A7C14`, `result = 32'h7F4A7C15`.
  - Done pulse at t+5, `pass = 1`, `errors = 0`, `fail_valid = 0`.
- Correct `add`, op_sel=1, count=1000: `busy` high exactly 1000 cycles; `pass = 1`; a second start reproduces the identical `data0`/`data1` sequence.
- `result` forced to 0, op_sel=0, count=100:
  - `errors` equals the number of vectors with nonzero expected sum (100 for SEED=1).
  - `fail_data0 = 32'h00000001`, `fail_data1 = 32'h7F4A7C14`, `pass = 0`.
- `result` forced to 0, count=70000: `errors = 16'hFFFF`, `pass = 0`, no wrap to 0.
- count=0: `done` at t+1, `pass = 1`, `busy` never high.
- Reset asserted at cycle t+3 of a count=10 run: next cycle all outputs 0 in IDLE; a restart yields full run results identical to an uninterrupted run.
